// File: rtl/osc_tri_squ_sin.sv
// osc_tri_squ_sin: period-driven phase accumulator emitting square/triangle samples and a sine ROM address.
// Period updates are deferred to the waveform wrap (or taken at once while idle) so the tone never glitches.
module osc_tri_squ_sin #(
   parameter int NBIT_PER   = 16,
   parameter int NBIT_PHASE = 5,
   parameter int AMP        = 16383,
   parameter int RST_PERIOD = 916
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     ce,
   input  logic                     gate,
   input  logic [NBIT_PER-1:0]      period_in,
   input  logic                     period_valid,
   output logic [NBIT_PHASE-1:0]    phase,
   output logic                     step_pulse,
   output logic                     cycle_start,
   output logic                     active,
   output logic signed [15:0]       squ_out,
   output logic signed [15:0]       tri_out
);
   localparam int HALF  = 2 ** (NBIT_PHASE - 1);
   localparam int TSTEP = 2 * (AMP + 1) / HALF;
   logic [NBIT_PER-1:0]   per_act, per_pend, cnt, nxt_pend, nxt_per, reload;
   logic [NBIT_PHASE-2:0] q;
   logic                  step, wrap;
   logic signed [15:0]    squ_w, tri_w;
   assign active   = rstn & gate & (per_act != '0);
   assign nxt_pend = period_valid ? period_in : per_pend;
   assign step     = active & ce & (cnt == '0);
   assign wrap     = step & (&phase);
   // a write landing on the wrap step bypasses the pending register
   assign nxt_per  = (wrap | ~active) ? nxt_pend : per_act;
   assign reload   = (nxt_per == '0) ? '0 : nxt_per - 1'b1;
   // second half of the cycle mirrors the first, giving the falling ramp
   assign q        = phase[NBIT_PHASE-1] ? ~phase[NBIT_PHASE-2:0] : phase[NBIT_PHASE-2:0];
   assign squ_w    = 16'(phase[NBIT_PHASE-1] ? -AMP : AMP);
   assign tri_w    = 16'(TSTEP * int'(q) - (AMP + 1));
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         per_act     <= NBIT_PER'(RST_PERIOD);
         per_pend    <= NBIT_PER'(RST_PERIOD);
         cnt         <= NBIT_PER'(RST_PERIOD - 1);
         phase       <= '0;
         step_pulse  <= 1'b0;
         cycle_start <= 1'b0;
         squ_out     <= '0;
         tri_out     <= '0;
      end else begin
         per_pend    <= nxt_pend;
         per_act     <= nxt_per;
         step_pulse  <= step;
         cycle_start <= wrap;
         squ_out     <= active ? squ_w : '0;
         tri_out     <= active ? tri_w : '0;
         if (!active) begin
            phase <= '0;
            cnt   <= reload;
         end else if (ce) begin
            phase <= step ? phase + 1'b1 : phase;
            cnt   <= step ? reload : cnt - 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_osc_tri_squ_sin.sv
// tb_osc_tri_squ_sin: directed + randomized stimulus against a behavioural oscillator model.
module tb_osc_tri_squ_sin;
   logic clk = 1'b0, rstn = 1'b0, ce = 1'b1, gate = 1'b1, period_valid = 1'b0;
   logic [15:0] period_in = '0;
   logic [4:0] phase;
   logic step_pulse, cycle_start, active;
   logic signed [15:0] squ_out, tri_out;
   int n_tests = 0, n_fail = 0;
   int m_pend, m_per, m_el, m_ph, m_sp, m_cs, m_squ, m_tri;

   osc_tri_squ_sin dut (
      .clk(clk), .rstn(rstn), .ce(ce), .gate(gate), .period_in(period_in),
      .period_valid(period_valid), .phase(phase), .step_pulse(step_pulse),
      .cycle_start(cycle_start), .active(active), .squ_out(squ_out), .tri_out(tri_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend = 916; m_per = 916; m_el = 0; m_ph = 0;
      m_sp = 0; m_cs = 0; m_squ = 0; m_tri = 0;
   endtask

   // one clock edge of the oscillator described in plain terms: elapsed clocks since last step
   task automatic model_edge();
      int newpend;
      bit act;
      act = gate && m_per != 0;
      newpend = period_valid ? int'(period_in) : m_pend;
      m_sp = 0; m_cs = 0;
      if (!act) begin
         m_per = newpend; m_ph = 0; m_el = 0; m_squ = 0; m_tri = 0;
      end else begin
         m_squ = (m_ph < 16) ? 16383 : -16383;
         m_tri = (m_ph < 16) ? m_ph * 2048 - 16384 : (31 - m_ph) * 2048 - 16384;
         if (ce) begin
            if (m_el + 1 >= m_per) begin
               m_sp = 1; m_el = 0;
               if (m_ph == 31) begin
                  m_cs = 1; m_per = newpend;
               end
               m_ph = (m_ph + 1) % 32;
            end else m_el++;
         end
      end
      m_pend = newpend;
   endtask

   task automatic check_all();
      check("phase", phase, m_ph);
      check("step_pulse", step_pulse, m_sp);
      check("cycle_start", cycle_start, m_cs);
      check("active", active, (gate && m_per != 0) ? 1 : 0);
      check("squ_out", squ_out, m_squ);
      check("tri_out", tri_out, m_tri);
   endtask

   // called at a negedge: drive, clock, check at the following negedge
   task automatic cyc(input logic g, input logic c, input logic v, input int p);
      gate = g; ce = c; period_valid = v; period_in = 16'(p);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_phase"}, phase, 0);
      check({tag, "_step"}, step_pulse, 0);
      check({tag, "_cs"}, cycle_start, 0);
      check({tag, "_active"}, active, 0);
      check({tag, "_squ"}, squ_out, 0);
      check({tag, "_tri"}, tri_out, 0);
   endtask

   initial begin
      model_reset();
      #23;
      @(negedge clk);
      check_reset_vals("rst");
      gate = 1'b0;
      rstn = 1'b1;
      repeat (10) cyc(0, 1, 0, 0);
      cyc(0, 1, 1, 4);
      repeat (300) cyc(1, 1, 0, 0);
      for (int i = 0; i < 200 && m_ph != 10; i++) cyc(1, 1, 0, 0);
      check("reach_ph10", phase, 10);
      cyc(1, 1, 1, 8);
      repeat (200) cyc(1, 1, 0, 0);
      for (int i = 0; i < 400 && !(m_ph == 31 && m_el == m_per - 1); i++) cyc(1, 1, 0, 0);
      check("pre_wrap_ph", phase, 31);
      cyc(1, 1, 1, 4);
      check("wrap_cs", cycle_start, 1);
      repeat (150) cyc(1, 1, 0, 0);
      cyc(1, 1, 1, 0);
      for (int i = 0; i < 200 && m_per != 0; i++) cyc(1, 1, 0, 0);
      repeat (3) cyc(1, 1, 0, 0);
      check("zero_idle", active, 0);
      cyc(1, 1, 1, 2);
      repeat (40) cyc(1, 1, 0, 0);
      cyc(1, 1, 1, 3);
      for (int i = 0; i < 100 && m_per != 3; i++) cyc(1, 1, 0, 0);
      for (int i = 0; i < 400; i++) cyc(1, logic'(i % 2), 0, 0);
      for (int i = 0; i < 400 && m_ph != 20; i++) cyc(1, 1, 0, 0);
      check("reach_ph20", phase, 20);
      cyc(0, 1, 0, 0);
      check("drop_phase", phase, 0);
      repeat (5) cyc(0, 1, 0, 0);
      repeat (50) cyc(1, 1, 0, 0);
      @(posedge clk);
      model_edge();
      #2 rstn = 1'b0;
      #1 check_reset_vals("midrst");
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
      repeat (20) cyc(1, 1, 0, 0);
      for (int i = 0; i < 3000; i++)
         cyc(logic'(($urandom % 16) != 0), logic'(($urandom % 4) != 0),
             logic'(($urandom % 8) == 0), int'($urandom_range(0, 5)));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
